alu_cc_stage: RTL

Pipelined Y86-64 execute-stage ALU and condition-code generator. It sits directly upstream of the 3-bit condition-code register: it computes valE for OPq/address arithmetic and produces new_cc {ZF,SF,OF} plus a single-cycle set_cc strobe that drive the CC register's data and set inputs. It is a two-stage pipeline with valid/ready flow control so decode can be back-pressured by later stages.

---
 rtl/alu_cc_stage_if.sv | 29 ++
 rtl/alu_cc_stage.sv | 127 ++++++++++++
 2 files changed

// File: rtl/alu_cc_stage_if.sv
// Operand/result bundle between decode, the execute ALU stage and the
// condition-code register. The ALU stage sits on the slave side.
interface alu_cc_stage_if #(
    parameter int W = 64
);
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   alufun;
    logic [W-1:0] aluA;
    logic [W-1:0] aluB;
    logic         op_sets_cc;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] valE;
    logic [2:0]   new_cc;
    logic         alu_err;
    logic         cc_suppress;
    logic         set_cc;

    modport master (
        output in_valid, alufun, aluA, aluB, op_sets_cc, out_ready, cc_suppress,
        input  in_ready, out_valid, valE, new_cc, alu_err, set_cc
    );

    modport slave (
        input  in_valid, alufun, aluA, aluB, op_sets_cc, out_ready, cc_suppress,
        output in_ready, out_valid, valE, new_cc, alu_err, set_cc
    );
endinterface

// File: rtl/alu_cc_stage.sv
// Two-stage Y86-64 execute ALU with condition-code generation.
// S1 holds the operands and computes the raw result, S2 holds the finished
// result and flags and drives the outputs. A valid/ready handshake on both
// ends lets later stages stall decode without losing or duplicating bundles.
module alu_cc_stage #(
    parameter int W = 64
) (
    input  logic           clk,
    input  logic           async_reset,
    alu_cc_stage_if.slave  bus
);

    localparam logic [3:0] FUN_ADD = 4'd0;
    localparam logic [3:0] FUN_SUB = 4'd1;
    localparam logic [3:0] FUN_AND = 4'd2;
    localparam logic [3:0] FUN_XOR = 4'd3;

    logic         s1_valid;
    logic [3:0]   s1_alufun;
    logic [W-1:0] s1_a;
    logic [W-1:0] s1_b;
    logic         s1_sets_cc;

    logic         s2_valid;
    logic [W-1:0] s2_val;
    logic [2:0]   s2_cc;
    logic         s2_err;
    logic         s2_sets_cc;

    logic         s2_adv;
    logic         s1_adv;
    logic         in_ready;
    logic         accept;

    logic [W-1:0] sum;
    logic [W-1:0] diff;
    logic [W-1:0] raw_val;
    logic         raw_of;
    logic         raw_err;
    logic [2:0]   raw_cc;

    // S2 can take a new bundle whenever it is empty or being drained; S1
    // may reload on the same edge it hands off, giving one bundle per cycle.
    assign s2_adv   = ~s2_valid | bus.out_ready;
    assign s1_adv   = s1_valid & s2_adv;
    assign in_ready = ~s1_valid | s2_adv;
    assign accept   = bus.in_valid & in_ready;

    assign sum  = s1_b + s1_a;
    assign diff = s1_b - s1_a;

    // Raw ALU result and flags for the operands held in S1; illegal function
    // codes produce a zero result with all flags cleared and the error bit set.
    always_comb begin
        raw_val = '0;
        raw_of  = 1'b0;
        raw_err = 1'b0;
        case (s1_alufun)
            FUN_ADD: begin
                raw_val = sum;
                raw_of  = (s1_a[W-1] == s1_b[W-1]) & (sum[W-1] != s1_a[W-1]);
            end
            FUN_SUB: begin
                raw_val = diff;
                raw_of  = (s1_a[W-1] != s1_b[W-1]) & (diff[W-1] != s1_b[W-1]);
            end
            FUN_AND: raw_val = s1_b & s1_a;
            FUN_XOR: raw_val = s1_b ^ s1_a;
            default: raw_err = 1'b1;
        endcase
        raw_cc = raw_err ? 3'b000 : {(raw_val == '0), raw_val[W-1], raw_of};
    end

    // S1 operand register: loads on accept, empties when it hands off with
    // nothing new arriving.
    always_ff @(posedge clk or negedge async_reset) begin
        if (!async_reset) begin
            s1_valid   <= 1'b0;
            s1_alufun  <= '0;
            s1_a       <= '0;
            s1_b       <= '0;
            s1_sets_cc <= 1'b0;
        end else begin
            if (in_ready) begin
                s1_valid <= bus.in_valid;
            end
            if (accept) begin
                s1_alufun  <= bus.alufun;
                s1_a       <= bus.aluA;
                s1_b       <= bus.aluB;
                s1_sets_cc <= bus.op_sets_cc;
            end
        end
    end

    // S2 result register: captures S1's result when S1 advances and holds it
    // stable until the downstream consumer takes it.
    always_ff @(posedge clk or negedge async_reset) begin
        if (!async_reset) begin
            s2_valid   <= 1'b0;
            s2_val     <= '0;
            s2_cc      <= 3'b000;
            s2_err     <= 1'b0;
            s2_sets_cc <= 1'b0;
        end else begin
            if (s2_adv) begin
                s2_valid <= s1_valid;
            end
            if (s1_adv) begin
                s2_val     <= raw_val;
                s2_cc      <= raw_cc;
                s2_err     <= raw_err;
                s2_sets_cc <= s1_sets_cc;
            end
        end
    end

    // The CC load strobe fires only in the consume cycle of a legal OPq that
    // no later-stage exception has cancelled.
    assign bus.set_cc    = s2_valid & bus.out_ready & s2_sets_cc & ~s2_err & ~bus.cc_suppress;
    assign bus.in_ready  = in_ready;
    assign bus.out_valid = s2_valid;
    assign bus.valE      = s2_val;
    assign bus.new_cc    = s2_cc;
    assign bus.alu_err   = s2_err;

endmodule
